reset_sequencer: RTL

Staged reset release controller that sits directly downstream of the reset synchronizer. It consumes the synchronized active-low reset and drives a vector of per-domain resets, releasing them one at a time with a programmable gap. It holds or re-runs the sequence on a hardware hold input or on a handshaked soft-reset request. After the full sequence completes it reports completion.

---
 rtl/reset_seq_pkg.sv | 23 ++
 rtl/reset_seq_timer.sv | 27 ++
 rtl/reset_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and configuration check for the staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } seq_state_t;

  function automatic bit cfg_ok(
    input int n,
    input int h,
    input int g,
    input int w
  );
    longint m;
    m = longint'((h > g) ? h : g) - 1;
    if (n < 1 || h < 1 || g < 1) return 1'b0;
    if (w < 1 || w > 62) return 1'b0;
    return m < (longint'(1) << w);
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Hold/gap interval counter with a combinational terminal-count flag.
module reset_seq_timer #(
  parameter int CNTW = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            clr,
  input  logic            en,
  input  logic [CNTW-1:0] cmp,
  output logic            tc
);

  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign tc = (cnt_q == cmp);

endmodule

// File: rtl/reset_sequencer.sv
// Staged per-domain reset release with hold input and handshaked soft reset.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int HOLD       = 8,
  parameter int GAP        = 4,
  parameter int CNTW       = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  FORCE_HOLD,
  input  logic                  EN_swReset,
  output logic                  RDY_swReset,
  output logic [NUM_STAGES-1:0] STAGE_RST_N,
  output logic                  ALL_DONE
);

  localparam int IDXW = $clog2(NUM_STAGES + 1);
  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_STAGES - 1);

  if (!cfg_ok(NUM_STAGES, HOLD, GAP, CNTW)) begin : g_bad_cfg
    $error("reset_sequencer: invalid NUM_STAGES/HOLD/GAP/CNTW");
  end

  seq_state_t            state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  done_q, done_d;
  logic                  clr, en, tc;
  logic [CNTW-1:0]       cmp;
  logic                  sw_fire;

  // Ready and done share one register, so a request is only seen in DONE.
  assign sw_fire = EN_swReset && done_q;
  assign cmp = (state_q == RELEASE) ? CNTW'(GAP - 1) : CNTW'(HOLD - 1);

  reset_seq_timer #(
    .CNTW(CNTW)
  ) u_timer (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clr  (clr),
    .en   (en),
    .cmp  (cmp),
    .tc   (tc)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ASSERT;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    en      = 1'b0;
    if (FORCE_HOLD || sw_fire) begin
      state_d = ASSERT;
      idx_d   = '0;
      stage_d = '0;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        RELEASE: begin
          en = 1'b1;
          if (tc) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
              if (idx_q == IDXW'(k)) stage_d[k] = 1'b1;
            end
            idx_d = idx_q + IDXW'(1);
            clr   = 1'b1;
            if (idx_q == LAST) state_d = DONE;
          end
        end
        DONE: begin
          done_d = 1'b1;
        end
        default: begin
          en = 1'b1;
          if (tc) begin
            stage_d[0] = 1'b1;
            idx_d      = IDXW'(1);
            clr        = 1'b1;
            state_d    = (NUM_STAGES == 1) ? DONE : RELEASE;
          end
        end
      endcase
    end
  end

  assign STAGE_RST_N = stage_q;
  assign ALL_DONE    = done_q;
  assign RDY_swReset = done_q;

endmodule
